// File: rtl/qam16_pkg.sv
// Shared constants and types for the 16-QAM hard-decision demapper.
// Levels and thresholds are Q5.11 two's complement.
package qam16_pkg;

    localparam int SAMP_W = 16;

    localparam logic signed [SAMP_W-1:0] LVL_P3 = 16'sh1800;
    localparam logic signed [SAMP_W-1:0] LVL_P1 = 16'sh0800;
    localparam logic signed [SAMP_W-1:0] LVL_N1 = 16'shF800;
    localparam logic signed [SAMP_W-1:0] LVL_N3 = 16'shE800;
    localparam logic signed [SAMP_W-1:0] THR_P  = 16'sh1000;
    localparam logic signed [SAMP_W-1:0] THR_N  = 16'shF000;

    typedef enum logic {EMPTY, HALF} pack_state_t;

    typedef logic [3:0] sym_t;

    // Nearest ideal level on either axis; the decision regions are axis independent.
    function automatic logic signed [SAMP_W-1:0] ideal_level(input logic signed [SAMP_W-1:0] v);
        if (v <= THR_N)
            return LVL_N3;
        else if (v[SAMP_W-1])
            return LVL_N1;
        else if (v < THR_P)
            return LVL_P1;
        else
            return LVL_P3;
    endfunction

endpackage

// File: rtl/qam16_slicer.sv
// Combinational single-axis slicer: maps one Q5.11 coordinate to its two symbol bits.
// AXIS_IMAG selects the quadrature bit mapping instead of the in-phase one.
module qam16_slicer
    import qam16_pkg::*;
#(
    parameter bit AXIS_IMAG = 1'b0
) (
    input  logic signed [SAMP_W-1:0] x,
    output logic        [1:0]        bits
);

    always_comb begin
        bits = 2'b00;
        if (!AXIS_IMAG) begin
            if (x <= THR_N)
                bits = 2'b00;
            else if (x[SAMP_W-1])
                bits = 2'b01;
            else if (x < THR_P)
                bits = 2'b11;
            else
                bits = 2'b10;
        end else begin
            if (x >= THR_P)
                bits = 2'b00;
            else if (!x[SAMP_W-1])
                bits = 2'b01;
            else if (x > THR_N)
                bits = 2'b11;
            else
                bits = 2'b10;
        end
    end

endmodule

// File: rtl/qam16_demapper.sv
// Hard-decision 16-QAM demapper: slice I/Q, pack symbol pairs into bytes with frame marking.
// Define QAM16_DEMAP_EVM_EN to add the per-frame error accumulator (err_sum/err_valid).
module qam16_demapper
    import qam16_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 8,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [IN_W-1:0]  inR,
    input  logic signed [IN_W-1:0]  inI,
    input  logic                    in_valid,
    input  logic                    in_last,
    output logic                    in_ready,
    output logic        [OUT_W-1:0] out_byte,
    output logic                    out_valid,
    output logic                    out_last,
    input  logic                    out_ready,
    output logic        [CNT_W-1:0] frame_cnt
`ifdef QAM16_DEMAP_EVM_EN
    ,
    output logic        [23:0]      err_sum,
    output logic                    err_valid
`endif
);

    logic [1:0]  bits_r, bits_i;
    sym_t        sym_in;
    logic        accept;

    sym_t        sym_p1;
    logic        last_p1;
    logic        vld_p1;

    pack_state_t state_q, state_d;
    sym_t        held_q;
    logic        xfer, emit;
    logic [OUT_W-1:0] byte_d;

    qam16_slicer #(.AXIS_IMAG(1'b0)) u_slice_r (.x(inR), .bits(bits_r));
    qam16_slicer #(.AXIS_IMAG(1'b1)) u_slice_i (.x(inI), .bits(bits_i));

    assign sym_in   = {bits_r, bits_i};
    assign in_ready = !vld_p1 || xfer;
    assign accept   = in_valid && in_ready;

    // ---- stage 0 -> stage 1: sliced symbol register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            vld_p1 <= 1'b0;
        else if (accept)
            vld_p1 <= 1'b1;
        else if (xfer)
            vld_p1 <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            sym_p1  <= sym_in;
            last_p1 <= in_last;
        end
    end

    // Storing a first nibble needs no output slot, so it never waits on out_ready.
    always_comb begin
        xfer    = vld_p1 && ((state_q == EMPTY && !last_p1) || !out_valid || out_ready);
        emit    = xfer && (state_q == HALF || last_p1);
        state_d = state_q;
        if (xfer)
            state_d = (state_q == EMPTY && !last_p1) ? HALF : EMPTY;
        byte_d  = (state_q == HALF) ? {held_q, sym_p1} : {sym_p1, 4'h0};
    end

    // ---- stage 1 -> stage 2: packer and output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= EMPTY;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (xfer && state_q == EMPTY && !last_p1)
            held_q <= sym_p1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_byte  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (emit) begin
            out_byte  <= byte_d;
            out_valid <= 1'b1;
            out_last  <= last_p1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            frame_cnt <= '0;
        else if (out_valid && out_ready && out_last)
            frame_cnt <= frame_cnt + 1'b1;
    end

`ifdef QAM16_DEMAP_EVM_EN
    logic [17:0] err_in;
    logic [17:0] err_p1;
    logic [23:0] acc_q;

    function automatic logic [16:0] abs_err(input logic signed [SAMP_W-1:0] v);
        logic signed [SAMP_W-1:0] lvl;
        logic signed [16:0]       d;
        lvl = ideal_level(v);
        d   = {v[SAMP_W-1], v} - {lvl[SAMP_W-1], lvl};
        return d[16] ? -d : d;
    endfunction

    function automatic logic [23:0] sat_add(input logic [23:0] a, input logic [17:0] b);
        logic [24:0] s;
        s = {1'b0, a} + {7'b0, b};
        return s[24] ? 24'hFFFFFF : s[23:0];
    endfunction

    assign err_in = {1'b0, abs_err(inR)} + {1'b0, abs_err(inI)};

    always_ff @(posedge clk) begin
        if (accept)
            err_p1 <= err_in;
    end

    // The closing symbol loads the total in the same cycle its byte is emitted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q     <= '0;
            err_sum   <= '0;
            err_valid <= 1'b0;
        end else begin
            err_valid <= 1'b0;
            if (xfer) begin
                if (last_p1) begin
                    err_sum   <= sat_add(acc_q, err_p1);
                    err_valid <= 1'b1;
                    acc_q     <= '0;
                end else begin
                    acc_q <= sat_add(acc_q, err_p1);
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_qam16_demapper.sv
// Directed bench for qam16_demapper: slicing boundaries, packing, backpressure, reset, latency.
// Build with QAM16_DEMAP_EVM_EN to also exercise the error accumulator.
module tb_qam16_demapper;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] inR, inI;
    logic        in_valid, in_last, in_ready;
    logic [7:0]  out_byte;
    logic        out_valid, out_last, out_ready;
    logic [15:0] frame_cnt;
`ifdef QAM16_DEMAP_EVM_EN
    logic [23:0] err_sum;
    logic        err_valid;
`endif

    int total = 0;
    int bad   = 0;
    logic [8:0] outs[$];

    always #5 clk = ~clk;

    qam16_demapper dut (
        .clk(clk), .rst(rst), .inR(inR), .inI(inI),
        .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .out_byte(out_byte), .out_valid(out_valid), .out_last(out_last),
        .out_ready(out_ready), .frame_cnt(frame_cnt)
`ifdef QAM16_DEMAP_EVM_EN
        , .err_sum(err_sum), .err_valid(err_valid)
`endif
    );

    // Record each byte handed off at the following rising edge.
    always @(negedge clk)
        if (!rst && out_valid && out_ready)
            outs.push_back({out_last, out_byte});

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] r, input logic [15:0] i, input logic l);
        int n;
        n = 0;
        inR = r; inI = i; in_last = l; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        total++;
        assert (n < 100) else begin
            bad++;
            $error("FAIL send_timeout observed=%0d cycles expected<100", n);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    function automatic logic [31:0] iq_of(input logic [3:0] s);
        logic [15:0] r, i;
        case (s[3:2])
            2'b00:   r = 16'hE800;
            2'b01:   r = 16'hF800;
            2'b11:   r = 16'h0800;
            default: r = 16'h1800;
        endcase
        case (s[1:0])
            2'b00:   i = 16'h1800;
            2'b01:   i = 16'h0800;
            2'b11:   i = 16'hF800;
            default: i = 16'hE800;
        endcase
        return {r, i};
    endfunction

    task automatic send_sym(input logic [3:0] s, input logic l);
        logic [31:0] v;
        v = iq_of(s);
        send(v[31:16], v[15:0], l);
    endtask

    task automatic expect_byte(input string tag, input int idx, input logic [8:0] exp);
        logic [31:0] obs;
        obs = (idx < outs.size()) ? {23'b0, outs[idx]} : 32'hFFFF_FFFF;
        check(tag, obs, {23'b0, exp});
    endtask

    initial begin
        int base;
        logic stable;
        logic [31:0] v;

        rst = 1'b1; inR = '0; inI = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        idle(3);
        check("rst_out_byte", out_byte, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_frame_cnt", frame_cnt, 0);
`ifdef QAM16_DEMAP_EVM_EN
        check("rst_err_sum", err_sum, 0);
        check("rst_err_valid", err_valid, 0);
`endif
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        idle(1);

        // Slicer boundaries and saturation
        base = outs.size();
        send(16'h0000, 16'h1000, 1'b0);
        send(16'hF000, 16'hFFFF, 1'b0);
        send(16'h8000, 16'h7FFF, 1'b0);
        send(16'h7FFF, 16'h8000, 1'b0);
        send(16'h0FFF, 16'hF001, 1'b0);
        send(16'hF001, 16'h0FFF, 1'b1);
        idle(5);
        check("bnd_count", outs.size() - base, 3);
        expect_byte("bnd_b0", base + 0, 9'h0C3);
        expect_byte("bnd_b1", base + 1, 9'h00A);
        expect_byte("bnd_b2", base + 2, 9'h1F5);
        check("bnd_frame_cnt", frame_cnt, 1);

        // All 16 ideal points, back to back
        base = outs.size();
        for (int k = 0; k < 16; k++)
            send_sym(4'(k), k == 15);
        idle(5);
        check("sweep_count", outs.size() - base, 8);
        for (int k = 0; k < 8; k++)
            expect_byte($sformatf("sweep_b%0d", k), base + k,
                        {(k == 7), 8'(8'h01 + 8'h22 * k)});
        check("sweep_frame_cnt", frame_cnt, 2);

        // Odd-length frame
        base = outs.size();
        send_sym(4'h5, 1'b0);
        send_sym(4'hA, 1'b0);
        send_sym(4'hC, 1'b1);
        idle(5);
        check("odd_count", outs.size() - base, 2);
        expect_byte("odd_b0", base + 0, 9'h05A);
        expect_byte("odd_b1", base + 1, 9'h1C0);
        check("odd_frame_cnt", frame_cnt, 3);

        // Backpressure: two symbols absorbed behind the held byte, then stall
        base = outs.size();
        out_ready = 1'b0;
        send_sym(4'h1, 1'b0);
        send_sym(4'h2, 1'b0);
        send_sym(4'h3, 1'b0);
        send_sym(4'h4, 1'b0);
        v = iq_of(4'h5);
        inR = v[31:16]; inI = v[15:0]; in_last = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        check("bp_in_ready_low", in_ready, 0);
        stable = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_byte !== 8'h12)
                stable = 1'b0;
        end
        check("bp_hold_stable", stable, 1);
        check("bp_no_handoff", outs.size() - base, 0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send_sym(4'h5, 1'b0);
        send_sym(4'h6, 1'b1);
        idle(6);
        check("bp_count", outs.size() - base, 3);
        expect_byte("bp_b0", base + 0, 9'h012);
        expect_byte("bp_b1", base + 1, 9'h034);
        expect_byte("bp_b2", base + 2, 9'h156);
        check("bp_frame_cnt", frame_cnt, 4);

        // Reset while a nibble is held
        base = outs.size();
        send_sym(4'h7, 1'b0);
        idle(2);
        rst = 1'b1;
        idle(1);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_frame_cnt", frame_cnt, 0);
        rst = 1'b0;
        idle(1);
        send_sym(4'h1, 1'b0);
        send_sym(4'h2, 1'b1);
        idle(5);
        check("mid_rst_count", outs.size() - base, 1);
        expect_byte("mid_rst_b0", base + 0, 9'h112);
        check("mid_rst_frame_cnt2", frame_cnt, 1);

        // Lone last symbol latency
        idle(3);
        send_sym(4'h9, 1'b1);
        @(negedge clk);
        check("lat_valid_early", out_valid, 0);
        @(negedge clk);
        check("lat_valid", out_valid, 1);
        check("lat_byte", out_byte, 8'h90);
        check("lat_last", out_last, 1);
        idle(3);
        check("lat_frame_cnt", frame_cnt, 2);

`ifdef QAM16_DEMAP_EVM_EN
        // (-2.9,+1.1),(+0.9,-3.2): errors 205+205+205+410
        send(16'hE8CD, 16'h08CD, 1'b0);
        send(16'h0733, 16'hE666, 1'b1);
        @(negedge clk);
        check("evm_valid_early", err_valid, 0);
        @(negedge clk);
        check("evm_valid", err_valid, 1);
        check("evm_sum", err_sum, 24'd1025);
        check("evm_out_valid", out_valid, 1);
        check("evm_byte", out_byte, 8'h1E);
        @(negedge clk);
        check("evm_pulse_end", err_valid, 0);
        idle(3);
        check("evm_frame_cnt", frame_cnt, 3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
